wdt_window: RTL and testbench

WDT_WINDOW -- requirements
Module: wdt_window

---
 rtl/wdt_window.sv | 200 ++++++++++++++++++++
 tb/tb_wdt_window.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/wdt_window.sv
// Windowed watchdog timer with CSR interface, pre-timeout interrupt and pulsed reset output.
// Optional early-kick window detection is compiled in with `define WDT_WINDOW_EN.
module wdt_window #(
  parameter int unsigned CNT_W           = 8,
  parameter int unsigned DEFAULT_TIMEOUT = 8'h3,
  parameter bit          DEFAULT_EN      = 1'b0,
  parameter int unsigned PULSE_TICKS     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic [4:0] csr_a,
  input  logic [7:0] csr_di,
  input  logic       csr_we,
  output logic [7:0] csr_do,
  output logic       wdt_out,
  output logic       force_recovery_mode,
  output logic       irq
);

  localparam logic [CNT_W-1:0] DefTimeout = CNT_W'(DEFAULT_TIMEOUT);
  localparam logic [CNT_W-1:0] DefLoad    = (DefTimeout == '0) ? CNT_W'(1) : DefTimeout;
  localparam logic [3:0]       PulseInit  = 4'(PULSE_TICKS);
  localparam logic [7:0]       KickKey    = 8'h6b;
`ifdef WDT_WINDOW_EN
  localparam logic [5:0]       CtrlMask   = 6'h3f;
`else
  localparam logic [5:0]       CtrlMask   = 6'h1f;
`endif

  localparam int unsigned CtrlEn    = 0;
  localparam int unsigned CtrlLock  = 1;
  localparam int unsigned CtrlOe    = 2;
  localparam int unsigned CtrlFrm   = 3;
  localparam int unsigned CtrlIrqEn = 4;
  localparam int unsigned CtrlWinEn = 5;

  localparam int unsigned StsPre     = 0;
  localparam int unsigned StsExpired = 1;
  localparam int unsigned StsEarly   = 2;

  typedef enum logic [1:0] {StIdle, StRun, StFire} state_e;
  localparam state_e StReset = DEFAULT_EN ? StRun : StIdle;

  state_e           state_q, state_d;
  logic [5:0]       ctrl_q, ctrl_d;
  logic [CNT_W-1:0] timeout_q, timeout_d;
  logic [7:0]       pretimeout_q, pretimeout_d;
  logic [2:0]       status_q, status_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       pulse_q, pulse_d;
`ifdef WDT_WINDOW_EN
  logic [7:0]       window_q, window_d;
`endif

  logic             wr_ctrl, wr_timeout_lo, wr_timeout_hi, wr_pre, wr_status, kick, early;
  logic [CNT_W-1:0] reload_val, cnt_dec;
  logic [15:0]      timeout16, cnt16;

  // Once LOCK is set, CTRL is frozen until reset.
  assign wr_ctrl       = csr_we && (csr_a == 5'h0) && !ctrl_q[CtrlLock];
  assign kick          = csr_we && (csr_a == 5'h1) && (csr_di == KickKey);
  assign wr_timeout_lo = csr_we && (csr_a == 5'h2);
  assign wr_timeout_hi = csr_we && (csr_a == 5'h3) && (CNT_W > 8);
  assign wr_pre        = csr_we && (csr_a == 5'h6);
  assign wr_status     = csr_we && (csr_a == 5'h8);

  assign reload_val = (timeout_q == '0) ? CNT_W'(1) : timeout_q;
  assign cnt_dec    = cnt_q - CNT_W'(1);
  assign timeout16  = 16'(timeout_q);
  assign cnt16      = 16'(cnt_q);

`ifdef WDT_WINDOW_EN
  assign early = ctrl_q[CtrlWinEn] && (window_q != 8'h0) && (cnt_q > CNT_W'(window_q));
`else
  assign early = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    ctrl_d       = ctrl_q;
    cnt_d        = cnt_q;
    pulse_d      = pulse_q;
    pretimeout_d = wr_pre ? csr_di : pretimeout_q;
    // Narrow builds truncate the high byte away, so HI writes vanish.
    timeout_d    = CNT_W'({wr_timeout_hi ? csr_di : timeout16[15:8],
                           wr_timeout_lo ? csr_di : timeout16[7:0]});
    status_d     = status_q & ~(wr_status ? csr_di[2:0] : 3'b000);
`ifdef WDT_WINDOW_EN
    window_d     = (csr_we && (csr_a == 5'h7)) ? csr_di : window_q;
`endif

    if (wr_ctrl) begin
      ctrl_d = csr_di[5:0] & CtrlMask;
      // EN is held while firing; the pulse always completes.
      if (state_q == StFire) ctrl_d[CtrlEn] = ctrl_q[CtrlEn];
    end

    case (state_q)
      StIdle: begin
        if (wr_ctrl && csr_di[CtrlEn]) begin
          state_d = StRun;
          cnt_d   = reload_val;
        end
      end
      StRun: begin
        if (wr_ctrl && !csr_di[CtrlEn]) begin
          state_d = StIdle;
        end else if (kick) begin
          if (early) begin
            state_d              = StFire;
            pulse_d              = PulseInit;
            status_d[StsExpired] = 1'b1;
            status_d[StsEarly]   = 1'b1;
          end else begin
            cnt_d = reload_val;
          end
        end else if (ce) begin
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d                = '0;
            state_d              = StFire;
            pulse_d              = PulseInit;
            status_d[StsExpired] = 1'b1;
          end else begin
            cnt_d = cnt_dec;
            if ((pretimeout_q != 8'h0) && (cnt_dec == CNT_W'(pretimeout_q))) begin
              status_d[StsPre] = 1'b1;
            end
          end
        end
      end
      StFire: begin
        if (ce) begin
          if (pulse_q <= 4'd1) begin
            if (ctrl_q[CtrlLock]) begin
              state_d = StRun;
              cnt_d   = reload_val;
            end else begin
              state_d        = StIdle;
              ctrl_d[CtrlEn] = 1'b0;
            end
          end else begin
            pulse_d = pulse_q - 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StReset;
      ctrl_q       <= {5'b0, DEFAULT_EN};
      timeout_q    <= DefTimeout;
      pretimeout_q <= 8'h0;
      status_q     <= 3'b000;
      cnt_q        <= DefLoad;
      pulse_q      <= 4'd0;
    end else begin
      state_q      <= state_d;
      ctrl_q       <= ctrl_d;
      timeout_q    <= timeout_d;
      pretimeout_q <= pretimeout_d;
      status_q     <= status_d;
      cnt_q        <= cnt_d;
      pulse_q      <= pulse_d;
    end
  end

`ifdef WDT_WINDOW_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) window_q <= 8'h0;
    else     window_q <= window_d;
  end
`endif

  always_comb begin
    csr_do = 8'h00;
    case (csr_a)
      5'h0: csr_do = {2'b00, ctrl_q};
      5'h2: csr_do = timeout16[7:0];
      5'h3: csr_do = timeout16[15:8];
      5'h4: csr_do = cnt16[7:0];
      5'h5: csr_do = cnt16[15:8];
      5'h6: csr_do = pretimeout_q;
`ifdef WDT_WINDOW_EN
      5'h7: csr_do = window_q;
`endif
      5'h8: csr_do = {5'b00000, status_q};
      default: csr_do = 8'h00;
    endcase
  end

  // Outputs decode from reset-cleared flops, so rst drops them asynchronously.
  assign wdt_out             = (state_q == StFire) && ctrl_q[CtrlOe];
  assign force_recovery_mode = (state_q == StFire) && ctrl_q[CtrlOe] && ctrl_q[CtrlFrm];
  assign irq                 = status_q[StsPre] && ctrl_q[CtrlIrqEn];

endmodule

// File: tb/tb_wdt_window.sv
// Directed self-checking bench for wdt_window with default parameters.
// Covers the window path when WDT_WINDOW_EN is defined, else checks it is absent.
module tb_wdt_window;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce = 1'b0;
  logic [4:0] csr_a = 5'h0;
  logic [7:0] csr_di = 8'h0;
  logic       csr_we = 1'b0;
  logic [7:0] csr_do;
  logic       wdt_out, force_recovery_mode, irq;

  int total = 0;
  int bad   = 0;

  wdt_window dut (
    .clk                 (clk),
    .rst                 (rst),
    .ce                  (ce),
    .csr_a               (csr_a),
    .csr_di              (csr_di),
    .csr_we              (csr_we),
    .csr_do              (csr_do),
    .wdt_out             (wdt_out),
    .force_recovery_mode (force_recovery_mode),
    .irq                 (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] a, input logic [7:0] exp);
    csr_a = a;
    #1;
    check(tag, csr_do, exp);
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    csr_a  = a;
    csr_di = d;
    csr_we = 1'b1;
    @(negedge clk);
    csr_we = 1'b0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ce = 1'b1;
      @(negedge clk);
      ce = 1'b0;
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reg("rst_ctrl", 5'h0, 8'h00);
    chk_reg("rst_timeout", 5'h2, 8'h03);
    chk_reg("rst_count", 5'h4, 8'h03);
    chk_reg("rst_status", 5'h8, 8'h00);
    chk_reg("rst_unmapped", 5'h1f, 8'h00);
    check("rst_outs", {5'b0, wdt_out, force_recovery_mode, irq}, 8'h00);

    // Enable with OE, no kicks: expire after 3 ticks, 2-tick pulse, EN clears
    wr(5'h0, 8'h05);
    chk_reg("en_count", 5'h4, 8'h03);
    tick(2);
    chk_reg("pre_exp_count", 5'h4, 8'h01);
    check("pre_exp_wdt", {7'b0, wdt_out}, 8'h00);
    tick(1);
    check("fire_wdt", {7'b0, wdt_out}, 8'h01);
    check("fire_frm_off", {7'b0, force_recovery_mode}, 8'h00);
    chk_reg("fire_status", 5'h8, 8'h02);
    chk_reg("fire_count", 5'h4, 8'h00);
    tick(1);
    check("fire_wdt_2nd", {7'b0, wdt_out}, 8'h01);
    tick(1);
    check("after_fire_wdt", {7'b0, wdt_out}, 8'h00);
    chk_reg("after_fire_ctrl", 5'h0, 8'h04);
    wr(5'h8, 8'h02);
    chk_reg("w1c_expired", 5'h8, 8'h00);

    // Pre-timeout interrupt, kick reload, W1C
    wr(5'h2, 8'd10);
    wr(5'h6, 8'd4);
    wr(5'h3, 8'hff);
    chk_reg("hi_ignored", 5'h3, 8'h00);
    wr(5'h0, 8'h11);
    tick(5);
    chk_reg("pre_count5", 5'h4, 8'd5);
    check("irq_low", {7'b0, irq}, 8'h00);
    tick(1);
    check("irq_high", {7'b0, irq}, 8'h01);
    chk_reg("pre_status", 5'h8, 8'h01);
    wr(5'h1, 8'h6b);
    chk_reg("kick_reload", 5'h4, 8'd10);
    wr(5'h8, 8'h01);
    check("irq_cleared", {7'b0, irq}, 8'h00);

    // Kick coinciding with the expiring tick wins
    tick(9);
    chk_reg("cnt_at_1", 5'h4, 8'd1);
    @(negedge clk);
    ce     = 1'b1;
    csr_a  = 5'h1;
    csr_di = 8'h6b;
    csr_we = 1'b1;
    @(negedge clk);
    ce     = 1'b0;
    csr_we = 1'b0;
    chk_reg("race_count", 5'h4, 8'd10);
    check("race_wdt", {7'b0, wdt_out}, 8'h00);
    chk_reg("race_status", 5'h8, 8'h01);
    tick(1);
    wr(5'h1, 8'h6a);
    chk_reg("bad_key", 5'h4, 8'd9);
    wr(5'h0, 8'h00);
    chk_reg("disable_ctrl", 5'h0, 8'h00);
    wr(5'h1, 8'h6b);
    tick(1);
    chk_reg("idle_hold", 5'h4, 8'd9);
    wr(5'h8, 8'hff);
    wr(5'h6, 8'h00);

`ifdef WDT_WINDOW_EN
    wr(5'h7, 8'd3);
    chk_reg("win_reg", 5'h7, 8'd3);
    wr(5'h0, 8'h25);
    tick(2);
    chk_reg("win_cnt8", 5'h4, 8'd8);
    wr(5'h1, 8'h6b);
    check("early_wdt", {7'b0, wdt_out}, 8'h01);
    chk_reg("early_status", 5'h8, 8'h06);
    tick(2);
    chk_reg("early_done_ctrl", 5'h0, 8'h24);
    wr(5'h8, 8'h07);
    wr(5'h0, 8'h25);
    tick(8);
    chk_reg("win_cnt2", 5'h4, 8'd2);
    wr(5'h1, 8'h6b);
    chk_reg("win_ok_reload", 5'h4, 8'd10);
    check("win_ok_wdt", {7'b0, wdt_out}, 8'h00);
    chk_reg("win_ok_status", 5'h8, 8'h00);
`else
    wr(5'h7, 8'd3);
    chk_reg("no_win_reg", 5'h7, 8'h00);
    wr(5'h0, 8'h25);
    chk_reg("no_win_ctrl", 5'h0, 8'h05);
    tick(2);
    wr(5'h1, 8'h6b);
    chk_reg("no_win_reload", 5'h4, 8'd10);
    check("no_win_wdt", {7'b0, wdt_out}, 8'h00);
    chk_reg("no_win_status", 5'h8, 8'h00);
`endif
    wr(5'h0, 8'h00);

    // LOCK: fire then rearm, CTRL frozen, TIMEOUT lands at next reload
    wr(5'h2, 8'd3);
    wr(5'h0, 8'h0f);
    tick(3);
    check("lock_wdt", {7'b0, wdt_out}, 8'h01);
    check("lock_frm", {7'b0, force_recovery_mode}, 8'h01);
    wr(5'h0, 8'h00);
    chk_reg("lock_ctrl_frozen", 5'h0, 8'h0f);
    tick(2);
    check("lock_rearm_wdt", {7'b0, wdt_out}, 8'h00);
    chk_reg("lock_rearm_cnt", 5'h4, 8'd3);
    wr(5'h2, 8'd5);
    chk_reg("lock_to_pending", 5'h4, 8'd3);
    tick(5);
    chk_reg("lock_to_applied", 5'h4, 8'd5);
    tick(5);
    check("lock_fire2", {7'b0, wdt_out}, 8'h01);

    // Reset mid-FIRE drops outputs immediately
    rst = 1'b1;
    #1;
    check("rst_mid_fire", {6'b0, wdt_out, force_recovery_mode}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    chk_reg("rst_unlock", 5'h0, 8'h00);
    chk_reg("rst_timeout2", 5'h2, 8'h03);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
